// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a - b over WIDTH cycles, LSB first, through a single
// difference/borrow cell with a registered borrow. Start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             borrow_q;
  logic [CW-1:0]    cnt;
  logic             x, y, d, bnext, last_bit;

  // Handshake: a start is taken only on an edge where ready=1 (IDLE);
  // done is a one-cycle pulse marking the cycle diff/borrow_out change.
  assign x        = a_sr[0];
  assign y        = b_sr[0];
  assign d        = x ^ y ^ borrow_q;
  assign bnext    = (~x & y) | (~(x ^ y) & borrow_q);
  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ready   <= (state_d == IDLE);
      busy    <= (state_d == SHIFT);
      done    <= (state_d == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      borrow_q   <= 1'b0;
      cnt        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr     <= a;
            b_sr     <= b;
            borrow_q <= 1'b0;
            cnt      <= '0;
          end
        end
        SHIFT: begin
          res_sr   <= {d, res_sr[WIDTH-1:1]};
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          borrow_q <= bnext;
          cnt      <= cnt + CW'(1);
          // Publish on the final bit edge so the result is visible in DONE.
          if (last_bit) begin
            diff       <= {d, res_sr[WIDTH-1:1]};
            borrow_out <= bnext;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 and WIDTH=4 instances, directed timing
// cases plus a randomized sweep scored against an arithmetic reference.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst8, start8, ready8, busy8, done8, borrow8;
  logic [7:0] a8, b8, diff8;
  logic       rst4, start4, ready4, busy4, done4, borrow4;
  logic [3:0] a4, b4, diff4;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int done_cnt8 = 0;
  int done_cnt4 = 0;
  logic done_prev8 = 1'b0;
  logic done_prev4 = 1'b0;

  logic [8:0] exp_q8[$];
  logic [4:0] exp_q4[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .diff(diff8), .borrow_out(borrow8)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4),
    .ready(ready4), .busy(busy4), .done(done4), .diff(diff4), .borrow_out(borrow4)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  // Reference: borrow flag and (x - y) mod 2^w packed as {borrow, diff}.
  function automatic int ref_sub(input int w, input int x, input int y);
    int m;
    int r;
    m = 1 << w;
    r = ((x - y) % m + m) % m;
    return ((x < y) ? m : 0) + r;
  endfunction

  // scoreboard: push on every accepting edge
  always @(posedge clk) begin
    if (!rst8 && start8 && ready8) exp_q8.push_back(9'(ref_sub(8, int'(a8), int'(b8))));
    if (!rst4 && start4 && ready4) exp_q4.push_back(5'(ref_sub(4, int'(a4), int'(b4))));
  end

  // monitor: pop and compare whenever done is presented
  always @(negedge clk) begin
    if (!rst8) begin
      if (done8) begin
        done_cnt8++;
        check("no_consec_done8", 32'(done_prev8), 32'd0);
        check("done8_flags", 32'({busy8, ready8}), 32'd0);
        check("exp8_available", 32'(exp_q8.size() != 0), 32'd1);
        if (exp_q8.size() != 0) check("result8", 32'({borrow8, diff8}), 32'(exp_q8.pop_front()));
      end
      done_prev8 = done8;
    end else done_prev8 = 1'b0;
    if (!rst4) begin
      if (done4) begin
        done_cnt4++;
        check("no_consec_done4", 32'(done_prev4), 32'd0);
        check("exp4_available", 32'(exp_q4.size() != 0), 32'd1);
        if (exp_q4.size() != 0) check("result4", 32'({borrow4, diff4}), 32'(exp_q4.pop_front()));
      end
      done_prev4 = done4;
    end else done_prev4 = 1'b0;
  end

  // driver tasks
  task automatic wait_ready8();
    for (int k = 0; k < 40 && !ready8; k++) begin @(posedge clk); #1; end
    if (!ready8) check("ready8_timeout", 32'(ready8), 32'd1);
  endtask

  task automatic wait_ready4();
    for (int k = 0; k < 40 && !ready4; k++) begin @(posedge clk); #1; end
    if (!ready4) check("ready4_timeout", 32'(ready4), 32'd1);
  endtask

  task automatic do_op8(input logic [7:0] x, input logic [7:0] y);
    wait_ready8();
    a8 = x; b8 = y; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  task automatic drain8();
    for (int k = 0; k < 60 && (exp_q8.size() != 0 || !ready8); k++) begin @(posedge clk); #1; end
    check("drain8", 32'(exp_q8.size() == 0 && ready8), 32'd1);
  endtask

  task automatic drain4();
    for (int k = 0; k < 60 && (exp_q4.size() != 0 || !ready4); k++) begin @(posedge clk); #1; end
    check("drain4", 32'(exp_q4.size() == 0 && ready4), 32'd1);
  endtask

  task automatic rand_ops8(input int n);
    for (int i = 0; i < n; i++) begin
      wait_ready8();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      case ($urandom_range(0, 7))
        0:       begin a8 = 8'h00; b8 = 8'($urandom); end
        1:       begin a8 = 8'($urandom); b8 = 8'hFF; end
        2:       begin a8 = 8'($urandom); b8 = a8; end
        default: begin a8 = 8'($urandom); b8 = 8'($urandom); end
      endcase
      start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom);
    end
  endtask

  task automatic rand_ops4(input int n);
    for (int i = 0; i < n; i++) begin
      wait_ready4();
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      a4 = 4'($urandom); b4 = 4'($urandom);
      start4 = 1'b1;
      @(posedge clk); #1;
      // occasionally hold start into the busy phase; it must be ignored
      start4 = ($urandom_range(0, 3) == 0);
      a4 = 4'($urandom); b4 = 4'($urandom);
      @(posedge clk); #1;
      start4 = 1'b0;
    end
  endtask

  initial begin
    int snap;
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0;
    rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst8_state", 32'({ready8, busy8, done8, borrow8, diff8}), 32'h800);
    check("rst4_state", 32'({ready4, busy4, done4, borrow4, diff4}), 32'h80);
    rst8 = 1'b0; rst4 = 1'b0;
    @(posedge clk); #1;

    // 200 - 55 with exact cycle timing; diff holds 0 while shifting
    a8 = 8'd200; b8 = 8'd55; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check("busy_phase8", 32'({busy8, ready8, done8, diff8}), 32'h400);
      @(posedge clk); #1;
    end
    check("done_cycle9", 32'({done8, busy8, ready8}), 32'h4);
    @(posedge clk); #1;
    check("ready_cycle10", 32'({ready8, busy8, done8}), 32'h4);

    do_op8(8'd5, 8'd9);     drain8();
    do_op8(8'd0, 8'd1);     drain8();
    do_op8(8'hA5, 8'hA5);   drain8();

    // back-to-back with start held: done every 10 cycles
    a8 = 8'd10; b8 = 8'd3; start8 = 1'b1;
    begin
      int last_done;
      last_done = -1;
      for (int p = 0; p < 3; p++) begin
        for (int k = 0; k < 30 && !done8; k++) begin @(posedge clk); #1; end
        check("b2b_done_seen", 32'(done8), 32'd1);
        if (last_done >= 0) check("b2b_spacing", 32'(cyc - last_done), 32'd10);
        last_done = cyc;
        if (p == 2) start8 = 1'b0;
        @(posedge clk); #1;
      end
    end
    drain8();

    // start and operand changes mid-operation are ignored
    snap = done_cnt8;
    do_op8(8'd100, 8'd1);
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'd1; b8 = 8'd100; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    drain8();
    repeat (12) @(posedge clk);
    #1;
    check("single_done", 32'(done_cnt8 - snap), 32'd1);
    check("held_diff99", 32'({borrow8, diff8}), 32'd99);

    // reset in cycle 4 aborts the op: outputs cleared, no done
    do_op8(8'd1, 8'd2);
    repeat (3) @(posedge clk);
    #1;
    rst8 = 1'b1;
    exp_q8.delete();
    @(posedge clk); #1;
    rst8 = 1'b0;
    check("abort_state", 32'({ready8, busy8, done8, borrow8, diff8}), 32'h800);
    snap = done_cnt8;
    repeat (14) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt8 - snap), 32'd0);
    do_op8(8'd1, 8'd2);     drain8();

    // randomized sweep on both widths in parallel
    fork
      rand_ops8(1000);
      rand_ops4(1000);
    join
    drain8();
    drain4();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor: computes a − b over WIDTH clock cycles, LSB first, using a one-bit difference/borrow cell with a registered borrow chain. Start/done handshake with a ready/busy status. It is the subtracting counterpart to the team's one-bit adder datapath and is intended to sit behind the tile's dedicated input and output pins.

Parameters:
WIDTH, 8, operand and result width in bits (≥2).

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset; synchronous, active-high
start  input  1  request a subtraction; sampled only when ready=1
a  input  WIDTH  minuend; captured on the accepting edge
b  input  WIDTH  subtrahend; captured on the accepting edge
ready  output  1  high in IDLE; a start is accepted only while high
busy  output  1  high while bits are being shifted (SHIFT state)
done  output  1  one-cycle pulse: diff and borrow_out updated this cycle
diff  output  WIDTH  (a − b) mod 2^WIDTH; holds the last result
borrow_out  output  1  final borrow; 1 if and only if a < b (unsigned); holds the last result

Behaviour:
- Reset, rst=1 at an edge:
  - state goes to IDLE; shift registers, bit counter and borrow register are cleared.
  - diff=0, borrow_out=0, done=0, busy=0, ready=1 from the next cycle.
  - Reset overrides start and aborts an in-flight operation. No done pulse follows an aborted operation.
- State machine: IDLE → SHIFT → DONE → IDLE.
  - IDLE: ready=1. If start=1 at an edge, capture a and b into shift registers, clear the borrow register and counter, then go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: busy=1, ready=0. Each edge processes one bit, with x=a_sr[0], y=b_sr[0], bin=borrow register:
    - d = x ^ y ^ bin
    - bnext = (~x & y) | (~(x ^ y) & bin)
    - d shifts into the MSB of the result register; a_sr and b_sr shift right; the borrow register takes bnext; the counter increments.
    - After the WIDTH-th bit edge, go to DONE.
  - DONE (exactly one cycle):
    - done=1, busy=0, ready=0.
    - diff shows the completed result register; borrow_out shows the final borrow.
    - Next edge returns to IDLE unconditionally.
- Timing: with start high in cycle 0 (IDLE), busy is high in cycles 1..WIDTH, done is high in cycle WIDTH+1, and ready is high again from cycle WIDTH+2. Latency is WIDTH+1 cycles; back-to-back throughput is one operation per WIDTH+2 cycles.
- start is ignored (not queued) in SHIFT and DONE. a and b changing after capture have no effect.
- diff and borrow_out change only in the DONE cycle or on reset. Between operations they hold the previous result, including while the next operation is in progress.
- Counter width is clog2(WIDTH)+1 bits; no wrap occurs within an operation.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then start with a=200, b=55 (WIDTH=8) → busy high for 8 cycles; done pulses at cycle 9; diff=145, borrow_out=0; ready at cycle 10.
- a=5, b=9 → diff=8'hFC (252), borrow_out=1. Then a=0, b=1 → diff=8'hFF, borrow_out=1. Then a=8'hA5, b=8'hA5 → diff=0, borrow_out=0.
- Back-to-back: start held high continuously with a=10, b=3 → results 7/0 on each done pulse. Done pulses are spaced exactly 10 cycles apart, and done is never high for 2 consecutive cycles.
- Start an op with a=100, b=1; in cycle 3 change a/b to 1/100 and pulse start → both ignored; diff=99, borrow_out=0; exactly one done pulse.
- Complete an op with diff=99, then start a=1, b=2 and assert rst in cycle 4 → next cycle diff=0, borrow_out=0, busy=0, ready=1; no done pulse. A fresh start with a=1, b=2 → diff=8'hFF, borrow_out=1.
- Randomised sweep, ≥1000 ops, WIDTH=8 and WIDTH=4 → diff equals (a−b) mod 2^WIDTH and borrow_out equals (a<b) every time.
